// File: rtl/id_pkg.sv
// Shared decode constants and enums for the instruction-decode stage.
package id_pkg;

    typedef enum logic [7:0] {
        ALU_NOP   = 8'd0,
        ALU_LUI   = 8'd1,
        ALU_AUIPC = 8'd2,
        ALU_JAL   = 8'd3,
        ALU_JALR  = 8'd4,
        ALU_BEQ   = 8'd5,
        ALU_BNE   = 8'd6,
        ALU_LW    = 8'd7,
        ALU_SW    = 8'd8,
        ALU_ADD   = 8'd9,
        ALU_SUB   = 8'd10,
        ALU_ADDI  = 8'd11
    } aluop_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef enum logic {
        ST_RUN,
        ST_WFI
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [31:0] WFI_INST = 32'h10500073;

endpackage

// File: rtl/id_stage_pipe_fwd.sv
// Operand resolver: regfile value or youngest matching forwarding source.
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned AW      = 5
) (
    input  logic                    rs_en,
    input  logic [AW-1:0]           rs_addr,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_is_load,
    input  logic [NUM_FWD*AW-1:0]   fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         value,
    output logic                    stall
);

    logic found;

    always_comb begin
        value = '0;
        stall = 1'b0;
        found = 1'b0;
        if (rs_en && rs_addr != '0) begin
            value = rf_data;
            // Lowest index is the youngest producer and must win.
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                if (!found && fwd_valid[k] && fwd_addr[k*AW +: AW] == rs_addr) begin
                    found = 1'b1;
                    if (fwd_is_load[k]) begin
                        stall = 1'b1;
                    end else begin
                        value = fwd_data[k*XLEN +: XLEN];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RISC-V decode stage with forwarding, load-use stall and WFI sleep.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned AW      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    irq_pending,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_inst,
    input  logic                    in_pc_invalid,
    output logic [AW-1:0]           rf_raddr1,
    output logic [AW-1:0]           rf_raddr2,
    input  logic [XLEN-1:0]         rf_rdata1,
    input  logic [XLEN-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_is_load,
    input  logic [NUM_FWD*AW-1:0]   fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_rs1_val,
    output logic [XLEN-1:0]         out_rs2_val,
    output logic [XLEN-1:0]         out_imm,
    output logic [AW-1:0]           out_rd,
    output logic                    out_wreg,
    output logic [7:0]              out_aluop,
    output logic [31:0]             out_inst,
    output logic                    out_pc_invalid,
    output logic                    out_inst_invalid,
    output logic                    load_stall,
    output logic                    wfi_sleep
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    aluop_e    dec_aluop;
    imm_type_e dec_imm;
    logic      dec_rs1_en, dec_rs2_en, dec_has_rd, dec_illegal, dec_wfi;
    logic [XLEN-1:0] dec_imm_val;
    logic [AW-1:0]   dec_rd;
    logic            dec_wreg;

    logic [XLEN-1:0] op1, op2;
    logic            stall1, stall2;
    logic            can_load, accept;

    state_e state_q, state_d;
    logic   wake_q;

    assign opcode    = in_inst[6:0];
    assign funct3    = in_inst[14:12];
    assign funct7    = in_inst[31:25];
    assign rf_raddr1 = AW'(in_inst[19:15]);
    assign rf_raddr2 = AW'(in_inst[24:20]);

    always_comb begin
        dec_aluop   = ALU_NOP;
        dec_imm     = IMM_NONE;
        dec_rs1_en  = 1'b0;
        dec_rs2_en  = 1'b0;
        dec_has_rd  = 1'b0;
        dec_illegal = 1'b0;
        dec_wfi     = 1'b0;
        case (opcode)
            OPC_LUI:   begin dec_aluop = ALU_LUI;   dec_imm = IMM_U; dec_has_rd = 1'b1; end
            OPC_AUIPC: begin dec_aluop = ALU_AUIPC; dec_imm = IMM_U; dec_has_rd = 1'b1; end
            OPC_JAL:   begin dec_aluop = ALU_JAL;   dec_imm = IMM_J; dec_has_rd = 1'b1; end
            OPC_JALR:
                if (funct3 == F3_JALR) begin
                    dec_aluop = ALU_JALR; dec_imm = IMM_I; dec_rs1_en = 1'b1; dec_has_rd = 1'b1;
                end else dec_illegal = 1'b1;
            OPC_BRANCH:
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    dec_aluop  = (funct3 == F3_BEQ) ? ALU_BEQ : ALU_BNE;
                    dec_imm    = IMM_B;
                    dec_rs1_en = 1'b1;
                    dec_rs2_en = 1'b1;
                end else dec_illegal = 1'b1;
            OPC_LOAD:
                if (funct3 == F3_LW) begin
                    dec_aluop = ALU_LW; dec_imm = IMM_I; dec_rs1_en = 1'b1; dec_has_rd = 1'b1;
                end else dec_illegal = 1'b1;
            OPC_STORE:
                if (funct3 == F3_SW) begin
                    dec_aluop = ALU_SW; dec_imm = IMM_S; dec_rs1_en = 1'b1; dec_rs2_en = 1'b1;
                end else dec_illegal = 1'b1;
            OPC_OPIMM:
                if (funct3 == F3_ADDI) begin
                    dec_aluop = ALU_ADDI; dec_imm = IMM_I; dec_rs1_en = 1'b1; dec_has_rd = 1'b1;
                end else dec_illegal = 1'b1;
            OPC_OP:
                if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
                    dec_aluop  = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                    dec_rs1_en = 1'b1;
                    dec_rs2_en = 1'b1;
                    dec_has_rd = 1'b1;
                end else dec_illegal = 1'b1;
            OPC_SYSTEM:
                if (in_inst == WFI_INST) dec_wfi = 1'b1;
                else dec_illegal = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_imm_val = '0;
        case (dec_imm)
            IMM_I:   dec_imm_val = XLEN'($signed(in_inst[31:20]));
            IMM_S:   dec_imm_val = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            IMM_B:   dec_imm_val = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                                  in_inst[11:8], 1'b0}));
            IMM_U:   dec_imm_val = XLEN'($signed({in_inst[31:12], 12'b0}));
            IMM_J:   dec_imm_val = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                                  in_inst[30:21], 1'b0}));
            default: dec_imm_val = '0;
        endcase
    end

    assign dec_rd   = dec_has_rd ? AW'(in_inst[11:7]) : '0;
    assign dec_wreg = dec_has_rd && (in_inst[11:7] != 5'd0);

    id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .AW(AW)) u_fwd_rs1 (
        .rs_en       (dec_rs1_en),
        .rs_addr     (rf_raddr1),
        .rf_data     (rf_rdata1),
        .fwd_valid   (fwd_valid),
        .fwd_is_load (fwd_is_load),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .value       (op1),
        .stall       (stall1)
    );

    id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .AW(AW)) u_fwd_rs2 (
        .rs_en       (dec_rs2_en),
        .rs_addr     (rf_raddr2),
        .rf_data     (rf_rdata2),
        .fwd_valid   (fwd_valid),
        .fwd_is_load (fwd_is_load),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .value       (op2),
        .stall       (stall2)
    );

    assign can_load   = !out_valid || out_ready;
    assign load_stall = rst_n && in_valid && (stall1 || stall2);
    assign in_ready   = rst_n && can_load && !load_stall && (state_q == ST_RUN) && !flush;
    assign accept     = in_valid && in_ready;
    assign wfi_sleep  = (state_q == ST_WFI);

    // wake_q remembers an interrupt seen while WFI itself was being accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wake_q  <= accept && dec_wfi && irq_pending;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (accept && dec_wfi) state_d = ST_WFI;
            ST_WFI:  if (irq_pending || wake_q) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (flush) state_d = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_pc           <= '0;
            out_rs1_val      <= '0;
            out_rs2_val      <= '0;
            out_imm          <= '0;
            out_rd           <= '0;
            out_wreg         <= 1'b0;
            out_aluop        <= ALU_NOP;
            out_inst         <= '0;
            out_pc_invalid   <= 1'b0;
            out_inst_invalid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid        <= 1'b1;
            out_pc           <= in_pc;
            out_rs1_val      <= op1;
            out_rs2_val      <= op2;
            out_imm          <= dec_imm_val;
            out_rd           <= dec_rd;
            out_wreg         <= dec_wreg;
            out_aluop        <= dec_aluop;
            out_inst         <= in_inst;
            out_pc_invalid   <= in_pc_invalid;
            out_inst_invalid <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus randomized traffic vs a reference model.
module tb_id_stage_pipe;
    import id_pkg::*;

    localparam int XLEN = 32;
    localparam int NUM_FWD = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, irq_pending, in_valid, in_ready, in_pc_invalid;
    logic [XLEN-1:0] in_pc, rf_rdata1, rf_rdata2;
    logic [31:0] in_inst;
    logic [AW-1:0] rf_raddr1, rf_raddr2;
    logic [NUM_FWD-1:0] fwd_valid, fwd_is_load;
    logic [AW-1:0] fa [NUM_FWD];
    logic [XLEN-1:0] fd [NUM_FWD];
    logic [NUM_FWD*AW-1:0] fwd_addr;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic out_valid, out_ready, out_wreg, out_pc_invalid, out_inst_invalid, load_stall, wfi_sleep;
    logic [XLEN-1:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [AW-1:0] out_rd;
    logic [7:0] out_aluop;
    logic [31:0] out_inst;

    assign fwd_addr = {fa[1], fa[0]};
    assign fwd_data = {fd[1], fd[0]};

    id_stage_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .irq_pending(irq_pending),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_pc_invalid(in_pc_invalid), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid),
        .fwd_is_load(fwd_is_load), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_wreg(out_wreg), .out_aluop(out_aluop), .out_inst(out_inst),
        .out_pc_invalid(out_pc_invalid), .out_inst_invalid(out_inst_invalid),
        .load_stall(load_stall), .wfi_sleep(wfi_sleep)
    );

    typedef struct packed {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic        wreg;
        logic [7:0]  aluop;
        logic [31:0] inst;
        logic        pc_inv, inst_inv;
    } pay_t;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic        wreg, use1, use2, inv;
    } dec_t;

    int n_checks = 0;
    int n_fail = 0;

    localparam logic [31:0] I_ADDI_X1_5 = 32'h00500093;
    localparam logic [31:0] I_ADD_X3    = 32'h002081B3;
    localparam logic [31:0] I_ADDI_X5_1 = 32'h00100293;
    localparam logic [31:0] I_ADDI_X6_2 = 32'h00200313;

    function automatic pay_t dut_pay();
        return '{pc:out_pc, rs1:out_rs1_val, rs2:out_rs2_val, imm:out_imm, rd:out_rd,
                 wreg:out_wreg, aluop:out_aluop, inst:out_inst,
                 pc_inv:out_pc_invalid, inst_inv:out_inst_invalid};
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        return 32'($signed(v << (32 - bits)) >>> (32 - bits));
    endfunction

    // {stall, value} for one operand read, from the forwarding rules.
    function automatic logic [32:0] resolve(input logic use_it, input logic [4:0] a, input logic [31:0] rf);
        if (!use_it || a == 5'd0) return 33'd0;
        for (int k = 0; k < NUM_FWD; k++)
            if (fwd_valid[k] && fa[k] == a) return fwd_is_load[k] ? {1'b1, 32'd0} : {1'b0, fd[k]};
        return {1'b0, rf};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; irq_pending = 1'b0;
        fwd_valid = '0; fwd_is_load = '0; in_pc_invalid = 1'b0; in_pc = 32'h0;
        rf_rdata1 = '0; rf_rdata2 = '0; in_inst = 32'h0;
        for (int k = 0; k < NUM_FWD; k++) begin fa[k] = '0; fd[k] = '0; end
    endtask

    // Builds a random instruction along with the decode it must produce.
    task automatic gen(output logic [31:0] inst, output dec_t d);
        logic [31:0] r, imm;
        logic [4:0] rd, s1, s2;
        logic has_rd;
        int kind;
        r = $urandom; rd = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
        if ($urandom_range(0, 7) == 0) rd = 5'd0;
        if ($urandom_range(0, 7) == 0) s1 = 5'd0;
        kind = $urandom_range(0, 11);
        d = '0; has_rd = 1'b0; imm = 32'd0;
        case (kind)
            0: begin imm = r & 32'hFFFFF000; inst = {imm[31:12], rd, 7'h37}; d.aluop = ALU_LUI; has_rd = 1'b1; end
            1: begin imm = r & 32'hFFFFF000; inst = {imm[31:12], rd, 7'h17}; d.aluop = ALU_AUIPC; has_rd = 1'b1; end
            2: begin
                imm = sx(r & 32'h1FFFFE, 21);
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
                d.aluop = ALU_JAL; has_rd = 1'b1;
            end
            3: begin
                imm = sx(r & 32'hFFF, 12); inst = {imm[11:0], s1, 3'b000, rd, 7'h67};
                d.aluop = ALU_JALR; has_rd = 1'b1; d.use1 = 1'b1;
            end
            4, 5: begin
                imm = sx(r & 32'h1FFE, 13);
                inst = {imm[12], imm[10:5], s2, s1, (kind == 4 ? 3'b000 : 3'b001), imm[4:1], imm[11], 7'h63};
                d.aluop = (kind == 4) ? ALU_BEQ : ALU_BNE; d.use1 = 1'b1; d.use2 = 1'b1;
            end
            6: begin
                imm = sx(r & 32'hFFF, 12); inst = {imm[11:0], s1, 3'b010, rd, 7'h03};
                d.aluop = ALU_LW; has_rd = 1'b1; d.use1 = 1'b1;
            end
            7: begin
                imm = sx(r & 32'hFFF, 12); inst = {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'h23};
                d.aluop = ALU_SW; d.use1 = 1'b1; d.use2 = 1'b1;
            end
            8: begin
                imm = sx(r & 32'hFFF, 12); inst = {imm[11:0], s1, 3'b000, rd, 7'h13};
                d.aluop = ALU_ADDI; has_rd = 1'b1; d.use1 = 1'b1;
            end
            9, 10: begin
                inst = {(kind == 10 ? 7'h20 : 7'h00), s2, s1, 3'b000, rd, 7'h33};
                d.aluop = (kind == 10) ? ALU_SUB : ALU_ADD; has_rd = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1;
            end
            default: begin
                inst = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : {7'h01, s2, s1, 3'b000, rd, 7'h33};
                d.aluop = ALU_NOP; d.inv = 1'b1;
            end
        endcase
        d.imm = imm; d.rs1 = s1; d.rs2 = s2;
        d.rd = has_rd ? rd : 5'd0;
        d.wreg = has_rd && rd != 5'd0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; in_valid = 1'b1; in_inst = I_ADD_X3;
        fwd_valid = 2'b01; fwd_is_load = 2'b01; fa[0] = 5'd1;
        #1;
        n_checks++; if (load_stall !== 1'b0) begin n_fail++; $display("FAIL reset_load_stall got %b want 0", load_stall); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (dut_pay() !== pay_t'(0)) begin n_fail++; $display("FAIL reset_payload got %h want 0", dut_pay()); end
        n_checks++; if (wfi_sleep !== 1'b0) begin n_fail++; $display("FAIL reset_wfi got %b want 0", wfi_sleep); end
        idle(); rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        idle(); in_inst = I_ADDI_X1_5; in_pc = 32'h100; in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b want 1", out_valid); end
        n_checks++;
        if ({out_aluop, out_rd, out_wreg, out_imm, out_rs1_val, out_pc} !== {ALU_ADDI, 5'd1, 1'b1, 32'd5, 32'd0, 32'h100}) begin
            n_fail++;
            $display("FAIL addi_fields got op=%0d rd=%0d w=%b imm=%h rs1=%h pc=%h want op=11 rd=1 w=1 imm=5 rs1=0 pc=100",
                     out_aluop, out_rd, out_wreg, out_imm, out_rs1_val, out_pc);
        end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b want 0", out_valid); end
    endtask

    task automatic test_forward_priority();
        idle(); in_inst = I_ADD_X3; in_valid = 1'b1;
        fwd_valid = 2'b11; fa[0] = 5'd1; fd[0] = 32'hAA; fa[1] = 5'd1; fd[1] = 32'hBB;
        rf_rdata1 = 32'h55; rf_rdata2 = 32'd7;
        #1;
        n_checks++; if ({rf_raddr1, rf_raddr2} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL raddr got %0d,%0d want 1,2", rf_raddr1, rf_raddr2); end
        step(); in_valid = 1'b0;
        n_checks++; if (out_rs1_val !== 32'hAA) begin n_fail++; $display("FAIL fwd_rs1 got %h want aa", out_rs1_val); end
        n_checks++; if (out_rs2_val !== 32'd7) begin n_fail++; $display("FAIL fwd_rs2 got %h want 7", out_rs2_val); end
        n_checks++; if ({out_aluop, out_rd} !== {ALU_ADD, 5'd3}) begin n_fail++; $display("FAIL fwd_add got op=%0d rd=%0d want 9,3", out_aluop, out_rd); end
    endtask

    task automatic test_load_use();
        idle(); in_inst = I_ADD_X3; in_valid = 1'b1; rf_rdata1 = 32'h55;
        fwd_valid = 2'b01; fwd_is_load = 2'b01; fa[0] = 5'd2; fd[0] = 32'h123;
        #1;
        n_checks++; if ({load_stall, in_ready} !== 2'b10) begin n_fail++; $display("FAIL lu_stall got stall=%b rdy=%b want 1,0", load_stall, in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %b want 0", out_valid); end
        fwd_is_load = 2'b00;
        #1;
        n_checks++; if ({load_stall, in_ready} !== 2'b01) begin n_fail++; $display("FAIL lu_release got stall=%b rdy=%b want 0,1", load_stall, in_ready); end
        step(); in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_rs1_val, out_rs2_val} !== {1'b1, 32'h55, 32'h123}) begin
            n_fail++; $display("FAIL lu_accept got v=%b rs1=%h rs2=%h want 1,55,123", out_valid, out_rs1_val, out_rs2_val);
        end
    endtask

    task automatic test_backpressure();
        idle(); in_inst = I_ADDI_X5_1; in_valid = 1'b1;
        step();
        in_inst = I_ADDI_X6_2; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready); end
            step();
            n_checks++;
            if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd5, 32'd1}) begin
                n_fail++; $display("FAIL bp_hold cyc%0d got v=%b rd=%0d imm=%h want 1,5,1", i, out_valid, out_rd, out_imm);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        n_checks++; if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd6, 32'd2}) begin n_fail++; $display("FAIL bp_next got v=%b rd=%0d imm=%h want 1,6,2", out_valid, out_rd, out_imm); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b want 0", out_valid); end
    endtask

    task automatic test_wfi();
        idle(); in_inst = WFI_INST; in_valid = 1'b1;
        step();
        n_checks++;
        if ({out_valid, out_aluop, out_wreg, out_inst_invalid, wfi_sleep} !== {1'b1, ALU_NOP, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL wfi_nop got v=%b op=%0d w=%b inv=%b sleep=%b want 1,0,0,0,1",
                               out_valid, out_aluop, out_wreg, out_inst_invalid, wfi_sleep);
        end
        in_inst = I_ADDI_X5_1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if ({in_ready, wfi_sleep} !== 2'b01) begin n_fail++; $display("FAIL wfi_sleep cyc%0d got rdy=%b sleep=%b want 0,1", i, in_ready, wfi_sleep); end
            step();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wfi_idle_out got %b want 0", out_valid); end
        irq_pending = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wfi_irq_cycle got %b want 0", in_ready); end
        step(); irq_pending = 1'b0;
        #1;
        n_checks++; if ({wfi_sleep, in_ready} !== 2'b01) begin n_fail++; $display("FAIL wfi_wake got sleep=%b rdy=%b want 0,1", wfi_sleep, in_ready); end
        step(); in_valid = 1'b0;
        n_checks++; if ({out_valid, out_rd} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL wfi_resume got v=%b rd=%0d want 1,5", out_valid, out_rd); end
        // interrupt already pending while WFI is accepted
        in_inst = WFI_INST; in_valid = 1'b1; irq_pending = 1'b1;
        step(); in_valid = 1'b0;
        n_checks++; if (wfi_sleep !== 1'b1) begin n_fail++; $display("FAIL wfi_irq_enter got %b want 1", wfi_sleep); end
        step(); irq_pending = 1'b0;
        n_checks++; if (wfi_sleep !== 1'b0) begin n_fail++; $display("FAIL wfi_irq_exit got %b want 0", wfi_sleep); end
        // flush aborts sleep
        in_inst = WFI_INST; in_valid = 1'b1;
        step(); in_valid = 1'b0; flush = 1'b1;
        step(); flush = 1'b0;
        n_checks++; if (wfi_sleep !== 1'b0) begin n_fail++; $display("FAIL wfi_flush got %b want 0", wfi_sleep); end
    endtask

    task automatic test_illegal_flush_reset();
        idle(); in_inst = 32'hFFFFFFFF; in_valid = 1'b1;
        step();
        n_checks++;
        if ({out_valid, out_inst_invalid, out_wreg, out_aluop, out_inst} !== {1'b1, 1'b1, 1'b0, ALU_NOP, 32'hFFFFFFFF}) begin
            n_fail++; $display("FAIL illegal got v=%b inv=%b w=%b op=%0d inst=%h want 1,1,0,0,ffffffff",
                               out_valid, out_inst_invalid, out_wreg, out_aluop, out_inst);
        end
        in_inst = I_ADDI_X5_1; out_ready = 1'b0; flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        step(); flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill got %b want 0", out_valid); end
        // flush together with an otherwise acceptable instruction drops it
        out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
        step(); flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %b want 0", out_valid); end
        in_valid = 1'b1; in_pc = 32'h40; in_pc_invalid = 1'b1;
        step(); out_ready = 1'b0; rst_n = 1'b0;
        step();
        n_checks++; if ({out_valid, dut_pay()} !== '0) begin n_fail++; $display("FAIL midreset got v=%b pay=%h want 0", out_valid, dut_pay()); end
        idle(); rst_n = 1'b1;
        step();
    endtask

    task automatic test_random(input int n);
        logic m_valid;
        pay_t m_pay;
        dec_t d;
        logic [31:0] inst;
        logic [32:0] r1, r2;
        logic exp_stall, exp_ready;
        idle(); step();
        m_valid = 1'b0; m_pay = '0;
        for (int i = 0; i < n; i++) begin
            n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid it%0d got %b want %b", i, out_valid, m_valid); end
            if (m_valid) begin
                n_checks++;
                if (dut_pay() !== m_pay) begin n_fail++; $display("FAIL rnd_payload it%0d got %h want %h", i, dut_pay(), m_pay); end
            end
            gen(inst, d);
            in_inst = inst;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc = $urandom & 32'hFFFFFFFC;
            in_pc_invalid = ($urandom_range(0, 7) == 0);
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            for (int k = 0; k < NUM_FWD; k++) begin
                fwd_valid[k] = ($urandom_range(0, 2) != 0);
                fwd_is_load[k] = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 2))
                    0: fa[k] = d.rs1;
                    1: fa[k] = d.rs2;
                    default: fa[k] = 5'($urandom);
                endcase
                fd[k] = $urandom;
            end
            #1;
            r1 = resolve(d.use1, d.rs1, rf_rdata1);
            r2 = resolve(d.use2, d.rs2, rf_rdata2);
            exp_stall = in_valid && (r1[32] || r2[32]);
            exp_ready = (!m_valid || out_ready) && !exp_stall;
            n_checks++; if (load_stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall it%0d inst=%h got %b want %b", i, inst, load_stall, exp_stall); end
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready it%0d got %b want %b", i, in_ready, exp_ready); end
            if (in_valid && exp_ready) begin
                m_valid = 1'b1;
                m_pay = '{pc:in_pc, rs1:r1[31:0], rs2:r2[31:0], imm:d.imm, rd:d.rd, wreg:d.wreg,
                          aluop:d.aluop, inst:inst, pc_inv:in_pc_invalid, inst_inv:d.inv};
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            step();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_addi();
        test_forward_priority();
        test_load_use();
        test_backpressure();
        test_wfi();
        test_illegal_flush_reset();
        test_random(2000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Registered, parametrised RISC-V instruction-decode stage between the IF/ID buffer and EX. It decodes one instruction per cycle into a registered ID/EX payload, with a valid/ready handshake on both sides. It resolves operands from the register file or from NUM_FWD forwarding sources, and stalls on load-use hazards. A two-state FSM implements WFI sleep until an interrupt is pending, and flush has priority over everything except reset.

Parameters:
XLEN, 32, datapath/register width (32 or 64)
NUM_FWD, 2, number of forwarding sources; index 0 = youngest (EX), highest priority
AW, 5, register address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
flush  in  1  kill payload and abort WFI
irq_pending  in  1  wakes WFI
in_valid  in  1  IF has an instruction
in_ready  out  1  ID accepts this cycle
in_pc  in  XLEN  instruction PC
in_inst  in  32  instruction word
in_pc_invalid  in  1  fetch fault tag
rf_raddr1, rf_raddr2  out  AW each  regfile read addresses (combinational from in_inst)
rf_rdata1, rf_rdata2  in  XLEN each  regfile read data
fwd_valid  in  NUM_FWD  source k will write its register
fwd_is_load  in  NUM_FWD  source k's data is not yet available (load)
fwd_addr  in  NUM_FWD*AW  destination register of source k
fwd_data  in  NUM_FWD*XLEN  result of source k
out_valid  out  1  payload valid to EX
out_ready  in  1  EX accepts payload
out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN each  registered operands
out_rd  out  AW  destination register
out_wreg  out  1  write-back enable
out_aluop  out  8  op code (package enum)
out_inst  out  32  raw instruction, for load/store sizing
out_pc_invalid  out  1  fetch fault passthrough
out_inst_invalid  out  1  illegal opcode/funct
load_stall  out  1  load-use hazard this cycle
wfi_sleep  out  1  FSM in WFI

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, all out_* fields 0, out_aluop=NOP, state=RUN. Combinational outputs (in_ready, load_stall) are 0 while rst_n=0.
- Decode set: LUI, AUIPC, JAL, JALR, BEQ, BNE, LW, SW, ADDI, ADD, SUB, WFI.
  - Any other encoding: out_inst_invalid=1, aluop=NOP, wreg=0. The payload still passes so the ctrl unit can trap.
- Immediates are sign-extended to XLEN: I, S, B (bit0=0), U (low 12 = 0), J (bit0=0).
- rd=x0 forces out_wreg=0.
- Operand read enables: rs1 for JALR, B, LW, SW, ADDI, ADD/SUB; rs2 for B, SW, ADD/SUB.
  - Operands that are not read are driven 0.
  - A read of x0 always yields 0 and never forwards or stalls.
- Forwarding: among sources with fwd_valid=1, the lowest k whose fwd_addr matches wins.
  - If that winning source has fwd_is_load=1, load_stall=1.
  - Otherwise its fwd_data is used; with no match, rf_rdata is used.
- Load-use: load_stall is combinational. It is asserted only when in_valid=1 and the operand is actually read.
- Handshake:
  - Define can_load = !out_valid | out_ready.
  - in_ready = can_load & !load_stall & state==RUN & !flush.
  - Accept = in_valid & in_ready. On accept the payload is registered and out_valid=1 next cycle.
  - If !accept and out_ready, then out_valid=0.
  - While out_valid & !out_ready, the payload is held bit-stable.
- Stall bubble: while load_stall=1 and can_load=1, out_valid goes to 0; EX receives no payload.
- FSM RUN->WFI: on accepting WFI, a NOP payload is emitted (aluop=NOP, wreg=0) and wfi_sleep=1 from the next cycle.
- FSM WFI->RUN: on irq_pending=1 (in_ready resumes next cycle) or on flush.
- flush (synchronous): next cycle out_valid=0 and state=RUN; in_ready=0 in the flush cycle. If accept and flush occur together, flush wins and the instruction is dropped.
- Simultaneous irq_pending and the WFI-accept cycle: the FSM still enters WFI and exits the following cycle.

Decomposition:
- Package id_pkg holds:
  - the aluop enum (NOP, LUI, AUIPC, JAL, JALR, BEQ, BNE, LW, SW, ADD, SUB, ADDI);
  - opcode/funct3/funct7 constants and the WFI encoding;
  - the FSM state enum;
  - the imm-type enum.
- Sub-module id_fwd_mux (one instance per operand): inputs are the read enable, rs address, rf data and the forwarding vectors; outputs are the operand value and a stall bit.

Test Plan:
1. ADDI x1,x0,5 with out_ready=1 -> one cycle later out_valid=1, aluop=ADDI, rd=1, wreg=1, imm=5, rs1_val=0.
2. ADD x3,x1,x2 with fwd0=(valid, x1, 0xAA) and fwd1=(valid, x1, 0xBB), rf_rdata2=7 -> rs1_val=0xAA, rs2_val=7.
3. ADD x3,x1,x2 with fwd0=(valid, load, x2) -> load_stall=1, in_ready=0, bubble (out_valid=0). Drop is_load next cycle -> instruction accepted with forwarded data.
4. Payload valid with out_ready=0 for 3 cycles while new instructions arrive -> out_* stable, in_ready=0. Release -> next instruction enters with no loss or duplication.
5. WFI, then irq_pending=0 for 4 cycles, then 1 -> NOP emitted, wfi_sleep=1, in_ready=0 for 4 cycles; RUN one cycle after irq.
6. Illegal 0xFFFFFFFF -> out_inst_invalid=1, wreg=0. Flush asserted with a valid payload -> out_valid=0 next cycle. rst_n=0 mid-stream -> all outputs 0.
